uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: recovers 8N1 frames (optionally 8E1) from the asynchronous `uart_rxd` pin and presents each received byte on a parallel bus with a single-cycle valid pulse. It pairs with `uart_tx` on the same link. It uses the same `BIT_RATE`/`CLK_HZ` parameterisation and the same LSB-first, idle-high line convention. It sits between the board-level RX pin and the system-side consumer (FIFO or register interface).

## Interface
- `BIT_RATE`, default 9600: line bit rate in bits/s.
- `CLK_HZ`, default 100000000: `clk` frequency in Hz.
- Derived constant `CYCLES_PER_BIT` = `CLK_HZ/BIT_RATE`. Legal range is 4..65535; this is an elaboration-time check.
- Derived constant `HALF_BIT` = `CYCLES_PER_BIT/2`.
- `clk`, input, 1: system clock.
- `resetn`, input, 1: reset. Asynchronous, active-low.
- `uart_rxd`, input, 1: asynchronous serial line. Idles high.
- `rx_enable`, input, 1: receiver enable. When low, the receiver is held in IDLE.
- `rx_busy`, output, 1: high whenever the state is not IDLE.
- `rx_data`, output, 8: last received byte. Holds its value until the next frame completes.
- `rx_valid`, output, 1: one-cycle pulse when `rx_data` is updated.
- `rx_frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `rx_parity_err`, output, 1: one-cycle pulse on parity mismatch. Present only with `UART_RX_PARITY_EN`.

## Operation
- `uart_rxd` passes through a 2-flop synchronizer to give `rxd_s`. A further register `rxd_q` holds the previous `rxd_s` for edge detection.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- `cnt` is a 16-bit bit-timing counter. It clears on every state change and otherwise increments.
- `bit_idx` is a 3-bit data-bit index.
- IDLE: move to START on a falling edge (`rxd_q`=1, `rxd_s`=0) while `rx_enable`=1. A line held low with no edge never starts a frame.
- START: when `cnt`=`HALF_BIT`-1, sample `rxd_s`.
  - If 0, move to DATA.
  - If 1 (glitch or false start), return to IDLE with no output pulse.
- DATA: when `cnt`=`CYCLES_PER_BIT`-1, shift `rxd_s` into the shift register LSB-first and increment `bit_idx`. After bit 7, move to STOP (or to PARITY with the macro).
- STOP: when `cnt`=`CYCLES_PER_BIT`-1, sample `rxd_s` and return to IDLE.
  - If 1: `rx_data` takes the shift register and `rx_valid` pulses.
  - If 0: `rx_frame_err` pulses, `rx_valid` stays low, and `rx_data` is unchanged.
- `rx_enable` low in any state forces IDLE at the next edge and discards the partial frame. If `rx_enable` falls in the same cycle as the stop sample, disable wins and there is no pulse.
- `rx_valid` and `rx_frame_err` are never high in the same cycle. The consumer has no backpressure: a byte not taken in the `rx_valid` cycle is still readable on `rx_data` until the next completion.

## Timing
- Reset values:
  - `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0, `rx_parity_err`=0, `rx_busy`=0.
  - State is IDLE. `cnt`=0.
  - The synchronizer flops and `rxd_q` reset to 1, so release of reset produces no false edge.
- Let the pin fall just before edge k. `rxd_s` is low after edge k+1 and START is entered at edge k+2.
- `rx_valid` is registered, high for exactly the one cycle following edge k+2+`HALF_BIT`+9*`CYCLES_PER_BIT`. With parity, add `CYCLES_PER_BIT`.
- Data bits are sampled at mid-bit, ±1 cycle of quantisation.
- Back-to-back frames: IDLE is entered at mid-stop-bit, so the next start edge is caught with zero idle time.
- Reset asserted mid-frame: all outputs immediately take their reset values; no pulse is emitted.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is 8E1. The PARITY state samples the bit at `cnt`=`CYCLES_PER_BIT`-1.
  - The received parity bit must equal the XOR of the 8 data bits; otherwise `rx_parity_err` pulses in the same cycle the frame would have raised `rx_valid`, and `rx_valid` is suppressed.
  - If the stop bit is also bad, only `rx_frame_err` pulses.
- Undefined: the frame is 8N1. There is no PARITY state and no `rx_parity_err` port.

## Structure
- Shared package `uart_pkg`: FSM state encodings, `CYCLES_PER_BIT`/`HALF_BIT` computation, and the parity function. Shared with `uart_tx`.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset value 1. Reusable for other asynchronous inputs.

## Test plan
Bench parameters: `CLK_HZ`=1000000, `BIT_RATE`=100000 (`CYCLES_PER_BIT`=10, `HALF_BIT`=5).
- Drive frame 0xA5 from an idle line → `rx_valid` is a single pulse 97 cycles after the pin falls, `rx_data`=0xA5, `rx_busy` drops in the same cycle.
- Drive a low glitch of 3 cycles on an idle line → no pulse, and the FSM is back in IDLE 7 cycles after the fall.
- Drive 0x3C with the stop bit low → one `rx_frame_err` pulse, no `rx_valid`, `rx_data` keeps its previous value. A following 0x81 is received correctly.
- Send 0x00 then 0xFF back-to-back with a 1-bit stop and no idle → two `rx_valid` pulses 100 cycles apart, carrying 0x00 then 0xFF.
- Drop `rx_enable` at bit 4 of 0x55, then reassert it → no pulse and immediate IDLE. A subsequent 0x55 is received.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `rx_parity_err` pulse and no `rx_valid`. With parity bit 1 → `rx_valid` and `rx_data`=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-timing derivation and parity.
// Used by both uart_rx and uart_tx.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic int unsigned half_bit(input int unsigned cpb);
    return cpb / 2;
  endfunction

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side bus of the UART receiver. rx_parity_err exists only when
// UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  import uart_pkg::*;

  logic                   rx_enable;
  logic                   rx_busy;
  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                   rx_parity_err;
`endif

  modport master (
    input  rx_enable,
    output rx_busy,
    output rx_data,
    output rx_valid,
`ifdef UART_RX_PARITY_EN
    output rx_parity_err,
`endif
    output rx_frame_err
  );

  modport slave (
    output rx_enable,
    input  rx_busy,
    input  rx_data,
    input  rx_valid,
`ifdef UART_RX_PARITY_EN
    input  rx_parity_err,
`endif
    input  rx_frame_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input; both flops reset high so an
// idle-high line shows no edge when reset is released.
module uart_rx_sync (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers 8N1 frames from uart_rxd onto a parallel byte bus with
// single-cycle valid/error pulses. Define UART_RX_PARITY_EN for 8E1 framing.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE = 9600,
  parameter int unsigned CLK_HZ   = 100000000
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      uart_rxd,
  uart_rx_if.master rx
);

  localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned HALF_BIT       = half_bit(CYCLES_PER_BIT);
  localparam logic [15:0] CNT_BIT_END    = 16'(CYCLES_PER_BIT - 1);
  localparam logic [15:0] CNT_HALF_END   = 16'(HALF_BIT - 1);

  if (CYCLES_PER_BIT < 4 || CYCLES_PER_BIT > 65535) begin : g_bad_rate
    $error("uart_rx: CLK_HZ/BIT_RATE must lie in 4..65535");
  end

  logic rxd_s;
  logic rxd_q, rxd_d;

  uart_state_e            state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   perr_q, perr_d;
`endif

  uart_rx_sync u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (uart_rxd),
    .q      (rxd_s)
  );

  always_comb begin
    rxd_d     = rxd_s;
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        bit_idx_d = '0;
        if (rxd_q && !rxd_s) state_d = ST_START;
      end
      ST_START: begin
        // A line back high at mid-start-bit was a glitch, not a frame.
        if (cnt_q == CNT_HALF_END) state_d = rxd_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d     = '0;
          shift_d   = {rxd_s, shift_q[UART_DATA_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = ST_PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_BIT_END) begin
          par_bad_d = (rxd_s != even_parity(shift_q));
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
        if (cnt_q == CNT_BIT_END) begin
          state_d = ST_IDLE;
          if (!rxd_s) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q || state_q == ST_IDLE) cnt_d = '0;

    if (!rx.rx_enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_q     <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rxd_q     <= rxd_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx.rx_busy      = (state_q != ST_IDLE);
  assign rx.rx_data      = data_q;
  assign rx.rx_valid     = valid_q;
  assign rx.rx_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rx.rx_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLK_HZ=1e6, BIT_RATE=1e5, 10 cycles/bit).
// Honours UART_RX_PARITY_EN for 8E1 framing.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_HZ   = 1000000;
  localparam int BIT_RATE = 100000;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int HALF     = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif
  // Pulse appears in the cycle after edge k+2+HALF+9*CPB (+CPB with parity).
  localparam int LAT = 2 + HALF + 9 * CPB + (PARITY_ON ? CPB : 0);

  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic uart_rxd = 1'b1;
  int   edge_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] last_data = 8'h00;

  uart_rx_if bus();

  uart_rx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .uart_rxd (uart_rxd),
    .rx       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         t;
    logic       v;
    logic       fe;
    logic       pe;
    logic       busy;
    logic [7:0] d;
  } obs_t;
  obs_t obs[$];
  logic pe_s;

  always @(negedge clk) begin
    pe_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_s = bus.rx_parity_err;
`endif
    if (bus.rx_valid || bus.rx_frame_err || pe_s)
      obs.push_back('{edge_cnt, bus.rx_valid, bus.rx_frame_err, pe_s, bus.rx_busy, bus.rx_data});
  end

  // Reference: what a complete frame should produce, from the line content alone.
  function automatic int model_kind(input logic stop_bit, input logic par_flip);
    if (!stop_bit) return K_FERR;
    if (PARITY_ON && par_flip) return K_PERR;
    return K_VALID;
  endfunction

  // Called at a negedge; leaves the line high at the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_flip, output int k);
    logic [9:0] bits;
    bits = {stop_bit, (^d) ^ par_flip, d};
    uart_rxd = 1'b0;
    k = edge_cnt + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = bits[i];
      repeat (CPB) @(negedge clk);
    end
    if (PARITY_ON) begin
      uart_rxd = bits[8];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = bits[9];
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.rx_enable = 1'b1;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.rx_busy, bus.rx_valid, bus.rx_frame_err, bus.rx_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b valid=%b ferr=%b data=%h, want all 0",
               bus.rx_busy, bus.rx_valid, bus.rx_frame_err, bus.rx_data);
    end
`ifdef UART_RX_PARITY_EN
    checks++;
    if (bus.rx_parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_perr: got %b want 0", bus.rx_parity_err);
    end
`endif
    resetn = 1'b1;
    idle(20);
    checks++;
    if (bus.rx_busy !== 1'b0 || obs.size() != 0) begin
      errors++;
      $display("FAIL reset_release: busy=%b pulses=%0d, want busy=0 pulses=0",
               bus.rx_busy, obs.size());
    end
    obs.delete();
  endtask

  task automatic test_frame_a5();
    int k;
    send_frame(8'hA5, 1'b1, 1'b0, k);
    last_data = 8'hA5;
    checks++;
    if (obs.size() != 1) begin
      errors++;
      $display("FAIL a5_count: got %0d pulses want 1", obs.size());
    end else if (obs[0].t != k + LAT || obs[0].v !== 1'b1 || obs[0].fe !== 1'b0 ||
                 obs[0].d !== 8'hA5) begin
      errors++;
      $display("FAIL a5_frame: got t=%0d v=%b fe=%b d=%h want t=%0d v=1 fe=0 d=a5",
               obs[0].t - k, obs[0].v, obs[0].fe, obs[0].d, LAT);
    end else begin
      checks++;
      if (obs[0].busy !== 1'b0) begin
        errors++;
        $display("FAIL a5_busy_drop: busy=%b at valid, want 0", obs[0].busy);
      end
    end
    obs.delete();
    idle(5);
  endtask

  task automatic test_glitch();
    int k;
    uart_rxd = 1'b0;
    k = edge_cnt + 1;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    checks++;
    if (bus.rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start: busy=%b want 1", bus.rx_busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_hold: busy=%b at fall+6 want 1", bus.rx_busy);
    end
    @(negedge clk);
    checks++;
    if (bus.rx_busy !== 1'b0 || edge_cnt != k + 7) begin
      errors++;
      $display("FAIL glitch_idle: busy=%b at fall+%0d want 0 at fall+7", bus.rx_busy, edge_cnt - k);
    end
    idle(120);
    checks++;
    if (obs.size() != 0) begin
      errors++;
      $display("FAIL glitch_pulse: got %0d pulses want 0", obs.size());
    end
    obs.delete();
  endtask

  task automatic test_frame_err();
    int k;
    send_frame(8'h3C, 1'b0, 1'b0, k);
    checks++;
    if (obs.size() != 1) begin
      errors++;
      $display("FAIL ferr_count: got %0d pulses want 1", obs.size());
    end else if (obs[0].t != k + LAT || obs[0].fe !== 1'b1 || obs[0].v !== 1'b0) begin
      errors++;
      $display("FAIL ferr_pulse: got t=%0d fe=%b v=%b want t=%0d fe=1 v=0",
               obs[0].t - k, obs[0].fe, obs[0].v, LAT);
    end
    checks++;
    if (bus.rx_data !== last_data) begin
      errors++;
      $display("FAIL ferr_hold: rx_data=%h want %h", bus.rx_data, last_data);
    end
    obs.delete();
    idle(5);
    send_frame(8'h81, 1'b1, 1'b0, k);
    last_data = 8'h81;
    checks++;
    if (obs.size() != 1 || obs[0].v !== 1'b1 || obs[0].d !== 8'h81 || obs[0].t != k + LAT) begin
      errors++;
      $display("FAIL ferr_recover: got n=%0d, want one valid of 81 at +%0d", obs.size(), LAT);
    end
    obs.delete();
    idle(5);
  endtask

  task automatic test_back_to_back();
    int k0, k1;
    send_frame(8'h00, 1'b1, 1'b0, k0);
    send_frame(8'hFF, 1'b1, 1'b0, k1);
    last_data = 8'hFF;
    checks++;
    if (obs.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses want 2", obs.size());
    end else begin
      checks++;
      if (obs[1].t - obs[0].t != CPB * (PARITY_ON ? 11 : 10)) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d want %0d", obs[1].t - obs[0].t, CPB * (PARITY_ON ? 11 : 10));
      end
      checks++;
      if (obs[0].v !== 1'b1 || obs[0].d !== 8'h00 || obs[1].v !== 1'b1 || obs[1].d !== 8'hFF) begin
        errors++;
        $display("FAIL b2b_data: got %h,%h want 00,ff", obs[0].d, obs[1].d);
      end
    end
    obs.delete();
    idle(5);
  endtask

  task automatic test_enable();
    int k;
    fork
      send_frame(8'h55, 1'b1, 1'b0, k);
      begin
        repeat (CPB * 5 + HALF) @(negedge clk);
        checks++;
        if (bus.rx_busy !== 1'b1) begin
          errors++;
          $display("FAIL en_busy_before: busy=%b want 1", bus.rx_busy);
        end
        bus.rx_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rx_busy !== 1'b0) begin
          errors++;
          $display("FAIL en_idle: busy=%b want 0", bus.rx_busy);
        end
      end
    join
    bus.rx_enable = 1'b1;
    idle(5);
    checks++;
    if (obs.size() != 0) begin
      errors++;
      $display("FAIL en_pulse: got %0d pulses want 0", obs.size());
    end
    obs.delete();
    send_frame(8'h55, 1'b1, 1'b0, k);
    last_data = 8'h55;
    checks++;
    if (obs.size() != 1 || obs[0].v !== 1'b1 || obs[0].d !== 8'h55) begin
      errors++;
      $display("FAIL en_resume: got n=%0d, want one valid of 55", obs.size());
    end
    obs.delete();
    idle(5);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int k;
    send_frame(8'h07, 1'b1, 1'b1, k);
    checks++;
    if (obs.size() != 1 || obs[0].pe !== 1'b1 || obs[0].v !== 1'b0 || obs[0].t != k + LAT) begin
      errors++;
      $display("FAIL par_bad: got n=%0d, want one parity error at +%0d", obs.size(), LAT);
    end
    obs.delete();
    idle(5);
    send_frame(8'h07, 1'b1, 1'b0, k);
    last_data = 8'h07;
    checks++;
    if (obs.size() != 1 || obs[0].v !== 1'b1 || obs[0].pe !== 1'b0 || obs[0].d !== 8'h07) begin
      errors++;
      $display("FAIL par_good: got n=%0d, want one valid of 07", obs.size());
    end
    obs.delete();
    idle(5);
  endtask
`endif

  task automatic test_random_frames();
    int k, kind, gap;
    logic [7:0] d;
    logic stop_bit, par_flip;
    for (int i = 0; i < 10; i++) begin
      d        = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 3) != 0);
      par_flip = PARITY_ON && ($urandom_range(0, 3) == 0);
      send_frame(d, stop_bit, par_flip, k);
      kind = model_kind(stop_bit, par_flip);
      if (kind == K_VALID) last_data = d;
      checks++;
      if (obs.size() != 1) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d pulses want 1", i, obs.size());
      end else if (obs[0].t != k + LAT || obs[0].v !== (kind == K_VALID) ||
                   obs[0].fe !== (kind == K_FERR) || obs[0].pe !== (kind == K_PERR)) begin
        errors++;
        $display("FAIL rand%0d_pulse: got t=%0d v=%b fe=%b pe=%b want t=%0d kind=%0d",
                 i, obs[0].t - k, obs[0].v, obs[0].fe, obs[0].pe, LAT, kind);
      end
      checks++;
      if (bus.rx_data !== last_data) begin
        errors++;
        $display("FAIL rand%0d_data: rx_data=%h want %h", i, bus.rx_data, last_data);
      end
      obs.delete();
      gap = stop_bit ? $urandom_range(0, 12) : $urandom_range(2, 12);
      idle(gap);
    end
    idle(5);
  endtask

  task automatic test_reset_midframe();
    int k;
    send_frame(8'hC3, 1'b1, 1'b0, k);
    obs.delete();
    idle(5);
    fork
      send_frame(8'h5A, 1'b1, 1'b0, k);
      begin
        repeat (50) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.rx_busy, bus.rx_valid, bus.rx_frame_err, bus.rx_data} !== 11'd0) begin
          errors++;
          $display("FAIL midreset_outputs: busy=%b valid=%b ferr=%b data=%h, want all 0",
                   bus.rx_busy, bus.rx_valid, bus.rx_frame_err, bus.rx_data);
        end
      end
    join
    resetn = 1'b1;
    idle(20);
    checks++;
    if (obs.size() != 0 || bus.rx_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_pulse: pulses=%0d data=%h want 0 pulses data=00", obs.size(), bus.rx_data);
    end
    obs.delete();
  endtask

  initial begin
    bus.rx_enable = 1'b1;
    @(negedge clk);
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_enable();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random_frames();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
